// File: rtl/note_pkg.sv
// Shared constants and types for the PS/2 note decoder.
// - Note indices C = 0 ... B = 11 (bit positions in the note register).
// - Set-2 scancodes for the twelve note keys and the control codes.
// - Receiver FSM state type and a scancode-to-note lookup helper.
package note_pkg;

    localparam int unsigned NUM_NOTES = 12;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    localparam logic [7:0] SC_C  = 8'h1C;
    localparam logic [7:0] SC_CS = 8'h1D;
    localparam logic [7:0] SC_D  = 8'h1B;
    localparam logic [7:0] SC_DS = 8'h24;
    localparam logic [7:0] SC_E  = 8'h23;
    localparam logic [7:0] SC_F  = 8'h2B;
    localparam logic [7:0] SC_FS = 8'h2C;
    localparam logic [7:0] SC_G  = 8'h34;
    localparam logic [7:0] SC_GS = 8'h35;
    localparam logic [7:0] SC_A  = 8'h33;
    localparam logic [7:0] SC_AS = 8'h3C;
    localparam logic [7:0] SC_B  = 8'h3B;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVR1 = 8'hFF;
    localparam logic [7:0] SC_BAT  = 8'hAA;
    localparam logic [7:0] SC_ACK  = 8'hFA;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } note_hit_t;

    function automatic note_hit_t note_lookup(input logic [7:0] code);
        note_hit_t res;
        res.hit = 1'b1;
        res.idx = NOTE_C;
        case (code)
            SC_C:    res.idx = NOTE_C;
            SC_CS:   res.idx = NOTE_CS;
            SC_D:    res.idx = NOTE_D;
            SC_DS:   res.idx = NOTE_DS;
            SC_E:    res.idx = NOTE_E;
            SC_F:    res.idx = NOTE_F;
            SC_FS:   res.idx = NOTE_FS;
            SC_G:    res.idx = NOTE_G;
            SC_GS:   res.idx = NOTE_GS;
            SC_A:    res.idx = NOTE_A;
            SC_AS:   res.idx = NOTE_AS;
            SC_B:    res.idx = NOTE_B;
            default: res.hit = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, falling-edge strobe,
// start/data/parity/stop FSM and inter-edge timeout.
// Ports:
//   i_clk, i_rst_n       system clock, async active-low reset
//   i_ps2_clk, i_ps2_dat raw keyboard lines (asynchronous)
//   o_byte               last accepted byte (registered)
//   o_valid              one-cycle pulse when o_byte updates
//   o_err                one-cycle pulse on start/parity/stop/timeout error
module ps2_rx
    import note_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_filt;
    logic          r_clk_filt_d;
    logic [FW-1:0] r_filt_cnt;
    rx_state_e     r_state;
    rx_state_e     w_state_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_err;

    logic w_clk_s;
    logic w_dat_s;
    logic w_strobe;
    logic w_timeout;
    logic w_accept;
    logic w_err_d;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // Lines idle high, so the synchronisers and filter reset to 1 to avoid a
    // spurious falling edge out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync   <= 2'b11;
            r_dat_sync   <= 2'b11;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync   <= {r_dat_sync[0], i_ps2_dat};
            r_clk_filt_d <= r_clk_filt;
            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_MAX) begin
                r_clk_filt <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_strobe  = r_clk_filt_d & ~r_clk_filt;
    // A strobe on the terminal count cycle wins over the timeout.
    assign w_timeout = (r_state != StIdle) && !w_strobe && (r_to_cnt == TO_MAX);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = StIdle;
        end else if (w_strobe) begin
            case (r_state)
                StIdle:   if (!w_dat_s) w_state_next = StData;
                StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
                StParity: w_state_next = StStop;
                StStop:   w_state_next = StIdle;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        w_accept = 1'b0;
        w_err_d  = 1'b0;
        if (w_timeout) begin
            w_err_d = 1'b1;
        end else if (w_strobe) begin
            case (r_state)
                StIdle: w_err_d = w_dat_s;
                StStop: begin
                    w_accept = w_dat_s & r_par_ok;
                    w_err_d  = ~(w_dat_s & r_par_ok);
                end
                default: ;
            endcase
        end
    end

    // Datapath: shift register, bit count, parity, timeout, registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_accept;
            r_err   <= w_err_d;
            if (w_accept) begin
                r_byte <= r_shift;
            end
            if (r_state == StIdle || w_strobe || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_strobe) begin
                case (r_state)
                    StIdle: r_bit_cnt <= '0;
                    StData: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    StParity: r_par_ok <= ^{r_shift, w_dat_s};
                    default: ;
                endcase
            end
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard to note-enable decoder. Turns set-2 make/break scancodes into
// twelve level-sensitive note enables (chords allowed) for the tone generator.
// Ports:
//   CLOCK_50, resetn        system clock, async active-low reset
//   PS2_CLK, PS2_DAT        keyboard lines
//   en_C ... en_B           note held enables (registered)
//   scan_code, scan_valid   last good byte and its one-cycle update pulse
//   frame_err               one-cycle pulse on any frame error
module ps2_note_decoder
    import note_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       en_C,
    output logic       en_Cs,
    output logic       en_D,
    output logic       en_Ds,
    output logic       en_E,
    output logic       en_F,
    output logic       en_Fs,
    output logic       en_G,
    output logic       en_Gs,
    output logic       en_A,
    output logic       en_As,
    output logic       en_B,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0]           w_byte;
    logic                 w_valid;
    logic                 w_err;
    logic [NUM_NOTES-1:0] r_notes;
    logic [NUM_NOTES-1:0] w_notes_d;
    logic                 r_ext;
    logic                 w_ext_d;
    logic                 r_brk;
    logic                 w_brk_d;
    note_hit_t            w_hit;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk     (CLOCK_50),
        .i_rst_n   (resetn),
        .i_ps2_clk (PS2_CLK),
        .i_ps2_dat (PS2_DAT),
        .o_byte    (w_byte),
        .o_valid   (w_valid),
        .o_err     (w_err)
    );

    assign w_hit = note_lookup(w_byte);

    always_comb begin
        w_notes_d = r_notes;
        w_ext_d   = r_ext;
        w_brk_d   = r_brk;
        if (w_err) begin
            w_ext_d = 1'b0;
            w_brk_d = 1'b0;
        end else if (w_valid) begin
            case (w_byte)
                SC_EXT: w_ext_d = 1'b1;
                SC_BRK: w_brk_d = 1'b1;
                SC_OVR0, SC_OVR1: begin
                    w_notes_d = '0;
                    w_ext_d   = 1'b0;
                    w_brk_d   = 1'b0;
                end
                SC_BAT, SC_ACK: begin
                    w_ext_d = 1'b0;
                    w_brk_d = 1'b0;
                end
                default: begin
                    // Extended codes share values with note keys but never play.
                    if (!r_ext && w_hit.hit) begin
                        w_notes_d[w_hit.idx] = ~r_brk;
                    end
                    w_ext_d = 1'b0;
                    w_brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_notes <= '0;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_notes <= w_notes_d;
            r_ext   <= w_ext_d;
            r_brk   <= w_brk_d;
        end
    end

    assign en_C  = r_notes[NOTE_C];
    assign en_Cs = r_notes[NOTE_CS];
    assign en_D  = r_notes[NOTE_D];
    assign en_Ds = r_notes[NOTE_DS];
    assign en_E  = r_notes[NOTE_E];
    assign en_F  = r_notes[NOTE_F];
    assign en_Fs = r_notes[NOTE_FS];
    assign en_G  = r_notes[NOTE_G];
    assign en_Gs = r_notes[NOTE_GS];
    assign en_A  = r_notes[NOTE_A];
    assign en_As = r_notes[NOTE_AS];
    assign en_B  = r_notes[NOTE_B];

    assign scan_code  = w_byte;
    assign scan_valid = w_valid;
    assign frame_err  = w_err;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: directed PS/2 frames, a byte-level reference
// model of the note register, and a per-cycle compare process.
module tb_ps2_note_decoder;

    logic       clk;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       en_C, en_Cs, en_D, en_Ds, en_E, en_F, en_Fs, en_G, en_Gs, en_A, en_As, en_B;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic [11:0] dut_en;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         err;
        logic [7:0] code;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [11:0] m_en;
    logic [7:0]  m_code;
    bit          m_ext;
    bit          m_brk;
    logic [7:0]  key_tab [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};

    ps2_note_decoder #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .en_C       (en_C),
        .en_Cs      (en_Cs),
        .en_D       (en_D),
        .en_Ds      (en_Ds),
        .en_E       (en_E),
        .en_F       (en_F),
        .en_Fs      (en_Fs),
        .en_G       (en_G),
        .en_Gs      (en_Gs),
        .en_A       (en_A),
        .en_As      (en_As),
        .en_B       (en_B),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    assign dut_en = {en_B, en_As, en_A, en_Gs, en_G, en_Fs, en_F, en_E, en_Ds, en_D, en_Cs, en_C};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level keyboard semantics applied to each accepted byte.
    function automatic void model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_en  = '0;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            if (!m_ext) begin
                for (int i = 0; i < 12; i++) begin
                    if (key_tab[i] == b) m_en[i] = !m_brk;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    // Compare process: every cycle, enables and scan_code against the model;
    // each pulse is matched against the next expected frame outcome.
    initial begin
        m_en = '0; m_code = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_en = '0; m_code = '0; m_ext = 1'b0; m_brk = 1'b0;
                chk("rst_en", {20'd0, dut_en}, 32'd0);
                chk("rst_pulses", {30'd0, scan_valid, frame_err}, 32'd0);
            end else begin
                chk("en_vs_model", {20'd0, dut_en}, {20'd0, m_en});
                if (scan_valid || frame_err)
                    chk("valid_err_exclusive", {31'd0, scan_valid & frame_err}, 32'd0);
                if (scan_valid) begin
                    chk("valid_expected", {31'd0, exp_q.size() != 0 && !exp_q[0].err}, 32'd1);
                    if (exp_q.size() != 0 && !exp_q[0].err) begin
                        chk("valid_code", {24'd0, scan_code}, {24'd0, exp_q[0].code});
                        void'(exp_q.pop_front());
                    end
                    model_byte(scan_code);
                end
                if (frame_err) begin
                    chk("err_expected", {31'd0, exp_q.size() != 0 && exp_q[0].err}, 32'd1);
                    if (exp_q.size() != 0 && exp_q[0].err) void'(exp_q.pop_front());
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
                chk("code_vs_model", {24'd0, scan_code}, {24'd0, m_code});
            end
        end
    end

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (20) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk("drain_bound", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        exp_t e;
        e.err  = bad_par;
        e.code = b;
        exp_q.push_back(e);
        send_bits(mk_frame(b, bad_par), 11);
        repeat (20) @(posedge clk);
        drain();
    endtask

    task automatic chk_en(input string name, input logic [11:0] exp);
        chk(name, {20'd0, dut_en}, {20'd0, exp});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        resetn  = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        #1 resetn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_en("reset_en", 12'h000);
        chk("reset_code", {24'd0, scan_code}, 32'd0);
        resetn = 1'b1;
        repeat (10) @(posedge clk);

        // 1: single make
        send_byte(8'h1C, 1'b0);
        chk_en("t1_en_C", 12'h001);
        chk("t1_code", {24'd0, scan_code}, 32'h1C);

        // 2: two keys, release one then the other
        send_byte(8'h1D, 1'b0);
        chk_en("t2_chord", 12'h003);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk_en("t2_break_C", 12'h002);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        chk_en("t2_all_off", 12'h000);

        // 3: three-note chord, release E, typematic repeat of C
        send_byte(8'h1C, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h34, 1'b0);
        chk_en("t3_chord", 12'h091);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        chk_en("t3_break_E", 12'h081);
        send_byte(8'h1C, 1'b0);
        chk_en("t3_repeat_C", 12'h081);

        // 4: parity error, then the same byte good
        send_byte(8'h1D, 1'b1);
        chk_en("t4_bad_parity", 12'h081);
        send_byte(8'h1D, 1'b0);
        chk_en("t4_good", 12'h083);

        // 5: truncated frame times out
        e.err  = 1'b1;
        e.code = 8'h00;
        exp_q.push_back(e);
        send_bits(mk_frame(8'h3B, 1'b0), 5);
        repeat (250) @(posedge clk);
        drain();
        chk_en("t5_after_timeout", 12'h083);
        send_byte(8'h3B, 1'b0);
        chk_en("t5_en_B", 12'h883);

        // 6: extended break does not release C; overrun clears all; reset mid-frame
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk_en("t6_ext_break", 12'h883);
        send_byte(8'hAA, 1'b0);
        chk_en("t6_bat_ignored", 12'h883);
        send_byte(8'h00, 1'b0);
        chk_en("t6_overrun", 12'h000);
        send_byte(8'h1C, 1'b0);
        chk_en("t6_pre_reset", 12'h001);
        send_bits(mk_frame(8'h1D, 1'b0), 4);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en("t6_reset_en", 12'h000);
        chk("t6_reset_code", {24'd0, scan_code}, 32'd0);
        chk("t6_reset_pulses", {30'd0, scan_valid, frame_err}, 32'd0);
        resetn = 1'b1;
        repeat (50) @(posedge clk);
        send_byte(8'h1D, 1'b0);
        chk_en("t6_after_reset", 12'h002);
        chk("t6_code_after_reset", {24'd0, scan_code}, 32'h1D);

        repeat (20) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Receives PS/2 keyboard frames and turns set-2 make/break scancodes into the twelve level-sensitive note enables (`en_C` … `en_B`) consumed by the square-wave tone generator. It is the stage directly upstream of `SoundOut`: each enable stays high while its key is held. Enables are independent, so chords are supported. It also exposes decoded bytes and frame errors for debug LEDs and HEX displays.

## Interface
Parameters:
- `FILTER_LEN`, 8: number of consecutive identical samples of synchronised `PS2_CLK` required to accept a level change (glitch filter).
- `TIMEOUT_CYCLES`, 50000: idle `CLOCK_50` cycles allowed between PS/2 falling edges inside a frame (1 ms) before the frame is aborted.

Ports (one clock; reset is asynchronous and active-low):
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `PS2_CLK`  in  1  keyboard clock, asynchronous to `CLOCK_50`.
- `PS2_DAT`  in  1  keyboard data, asynchronous to `CLOCK_50`.
- `en_C`, `en_Cs`, `en_D`, `en_Ds`, `en_E`, `en_F`, `en_Fs`, `en_G`, `en_Gs`, `en_A`, `en_As`, `en_B`  out  1 each  note held.
- `scan_code`  out  8  last good byte received.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  out  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
Input conditioning:
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchroniser.
- The clock then passes through the `FILTER_LEN` glitch filter.
- A falling edge of the filtered clock produces one strobe cycle; the data bit is sampled on that cycle.

Receiver FSM (`IDLE`, `DATA`, `PARITY`, `STOP`):
- `IDLE`: on strobe, if data = 0 go to `DATA` with bit count = 0; otherwise stay in `IDLE` and pulse `frame_err`.
- `DATA`: on each strobe, shift the sampled bit in LSB first; after 8 bits go to `PARITY`.
- `PARITY`: on strobe, check for odd parity over data and parity bit; latch the result and go to `STOP`.
- `STOP`: on strobe, go to `IDLE`. If stop = 1 and parity is good, the byte is accepted; otherwise pulse `frame_err`.
- Timeout: in any state other than `IDLE`, a strobe-free run of `TIMEOUT_CYCLES` cycles forces `IDLE` and pulses `frame_err`. The timeout counter clears on every strobe.

Scancode decoder (runs on each accepted byte):
- `E0`: set the `ext` flag; no note change.
- `F0`: set the `brk` flag; no note change.
- `00` or `FF` (keyboard overrun): clear all twelve enables and both flags.
- `AA` and `FA`: ignored; both flags cleared.
- Other codes with `ext` = 0: look up the note map. A hit sets the enable (or clears it when `brk` = 1). A miss changes nothing. Both flags clear.
- Other codes with `ext` = 1: never map to a note; both flags clear.
- A frame error also clears `ext` and `brk`.

Note map (set 2 scancodes):
- C = 1C (A), C# = 1D (W), D = 1B (S), D# = 24 (E), E = 23 (D)
- F = 2B (F), F# = 2C (T), G = 34 (G), G# = 35 (Y)
- A = 33 (H), A# = 3C (U), B = 3B (J)

Behaviour of the enables:
- Typematic repeats of a held key re-set an already-set bit; the enable does not glitch.
- A break for a key that is not held is harmless.

## Timing
- Reset values: all `en_*` = 0, `scan_code` = 00, `scan_valid` = 0, `frame_err` = 0, FSM in `IDLE`, flags and counters cleared.
- Reset asserted mid-frame discards the partial frame; the next start bit is decoded normally.
- Input latency: 2 sync stages plus `FILTER_LEN` from a pin edge to the strobe.
- Let N be the strobe cycle of the stop bit:
  - cycle N+1: `scan_valid` = 1 with `scan_code` valid (or `frame_err` = 1 instead);
  - cycle N+2: `en_*` reflects the byte.
- Every `en_*` is registered and changes at most once per accepted byte.
- A timeout `frame_err` pulses on the cycle after the counter reaches `TIMEOUT_CYCLES`−1.
- `scan_valid` and `frame_err` are never high in the same cycle.

## Structure
- Package `note_pkg` holds:
  - the note index constants (C = 0 … B = 11);
  - the scancode constants for the 12 keys plus `E0`, `F0`, `00`, `FF`, `AA`, `FA`;
  - the receiver state typedef.
- Sub-module `ps2_rx` contains the synchroniser, glitch filter, FSM and timeout counter. It outputs `byte`, `valid` and `err`.
- The top level holds the decoder flags, the 12-bit note register and the fan-out to the `en_*` ports.

## Test plan
Simulate with `FILTER_LEN` = 4, `TIMEOUT_CYCLES` = 200 and a PS/2 clock period of 40 cycles.

1. Frame 1C → `scan_valid` with `scan_code` = 1C at N+1; `en_C` = 1 at N+2; all other enables stay 0.
2. 1C, then 1D, then F0 1C → `en_C` = 0 and `en_Cs` stays 1; after F0 1D, all enables are 0.
3. 1C, 23, 34, then F0 23 → `en_C` = 1, `en_E` = 0, `en_G` = 1; a repeated 1C leaves `en_C` at 1 with no glitch.
4. 1D sent with even parity → `frame_err` pulses, no `scan_valid`, `en_Cs` stays 0. A following good 1D sets `en_Cs` = 1.
5. Five bits of a frame, then idle for 250 cycles → `frame_err` pulses once; a following good 3B sets `en_B` = 1.
6. With `en_C` = 1: E0 F0 1C → `en_C` stays 1. Then 00 → all enables 0. Then `resetn` pulsed low mid-frame → all outputs return to reset values.
